// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data memory between the core load/store path (port 0) and the
//   debug/program-loader path (port 1). Grants are combinational (zero
//   latency), at most one per cycle. Read responses return to the issuing
//   port RD_LAT cycles after the grant, in issue order, through a
//   valid/owner shift register. A requester holding lock keeps exclusive
//   ownership for back-to-back (e.g. read-modify-write) accesses.
//
//   Build option: DMEM_ARB_RR_EN
//     defined   -> round-robin arbitration in ARB (one-bit last-grant pointer)
//     undefined -> fixed priority, port 0 wins every conflict
//
//   Parameters: AW address width, DW data width, RD_LAT memory read latency
//   (legal 1..4).
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     reqN, weN, lockN          request, write(1)/read(0), keep ownership
//     addrN, wdataN             byte address, write data
//     gntN                      request accepted this cycle (combinational)
//     rvalidN, rdataN           read response pulse and data for port N
//     mem_en, mem_rw            memory access strobe, 1 = write
//     mem_addr, mem_wdata       memory address / write data (0 when idle)
//     mem_rdata                 memory read data, RD_LAT cycles after issue
//
//   State | meaning
//   ARB   | no owner; arbitrate between requesters
//   LOCK0 | port 0 owns the memory; port 1 requests ignored
//   LOCK1 | port 1 owns the memory; port 0 requests ignored
module dmem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   g0, g1;

`ifdef DMEM_ARB_RR_EN
  // Last port granted in ARB; resets to 1 so port 0 wins the first conflict.
  logic last_q, last_d;
`endif

  // Ownership FSM and grant selection
  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    state_d = state_q;
`ifdef DMEM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ARB: begin
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
          if (last_q) g0 = 1'b1;
          else        g1 = 1'b1;
`else
          g0 = 1'b1;
`endif
        end else begin
          g0 = req0;
          g1 = req1;
        end
        // Only the winner's lock counts.
        if (g0 && lock0)      state_d = LOCK0;
        else if (g1 && lock1) state_d = LOCK1;
`ifdef DMEM_ARB_RR_EN
        if (g0)      last_d = 1'b0;
        else if (g1) last_d = 1'b1;
`endif
      end
      LOCK0: begin
        g0 = req0;
        // Leave on an unlocked access or when the owner drops its request.
        if (!req0 || !lock0) state_d = ARB;
      end
      LOCK1: begin
        g1 = req1;
        if (!req1 || !lock1) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    // Nothing is granted while reset is applied.
    if (rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  assign gnt0 = g0;
  assign gnt1 = g1;

  // Memory side: winner's fields pass straight through, zeros when idle.
  always_comb begin
    mem_en    = g0 | g1;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (g0) begin
      mem_rw    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (g1) begin
      mem_rw    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Read tracking: stage 0 is loaded in the grant cycle, so the entry is at
  // stage RD_LAT-1 exactly RD_LAT cycles later, when mem_rdata is valid.
  logic              rd_push;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] own_q, own_d;

  assign rd_push = (g0 && !we0) || (g1 && !we1);

  always_comb begin
    vld_d    = '0;
    own_d    = '0;
    vld_d[0] = rd_push;
    own_d[0] = g1;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  logic          rv0, rv1;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  assign rv0 = vld_q[RD_LAT-1] && !own_q[RD_LAT-1] && !rst;
  assign rv1 = vld_q[RD_LAT-1] &&  own_q[RD_LAT-1] && !rst;

  // Data is bypassed in the rvalid cycle and held in a register afterwards.
  assign rdata0_d = rv0 ? mem_rdata : rdata0_q;
  assign rdata1_d = rv1 ? mem_rdata : rdata1_q;

  assign rvalid0 = rv0;
  assign rvalid1 = rv1;
  assign rdata0  = rst ? '0 : rdata0_d;
  assign rdata1  = rst ? '0 : rdata1_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      vld_q    <= '0;
      own_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      own_q    <= own_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RD_LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic          lock0 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: word array plus RD_LAT-deep read data pipe.
  logic [DW-1:0] mem [16] = '{
    32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C,
    32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0,
    32'h5555_0020, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0};
  logic [DW-1:0] pipe [RD_LAT];

  always @(posedge clk) begin
    if (mem_en && mem_rw) mem[mem_addr[5:2]] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_rw) ? mem[mem_addr[5:2]] : 32'h0BAD_0BAD;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   sb_en    = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus: drive at negedge, check combinational outputs,
  // and queue the expected read response for the granted port.
  task automatic step(input logic rst_v,
                      input logic r0, input logic w0, input logic l0,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic eg0, input logic eg1, input logic [DW-1:0] erd);
    exp_t e;
    @(negedge clk);
    rst = rst_v;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #2;
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("mem_en", mem_en, eg0 | eg1);
    if (eg0) begin
      chk("mem_rw", mem_rw, w0);
      chk("mem_addr", mem_addr, a0);
      chk("mem_wdata", mem_wdata, d0);
    end else if (eg1) begin
      chk("mem_rw", mem_rw, w1);
      chk("mem_addr", mem_addr, a1);
      chk("mem_wdata", mem_wdata, d1);
    end else begin
      chk("idle_mem_rw", mem_rw, 0);
      chk("idle_mem_addr", mem_addr, 0);
      chk("idle_mem_wdata", mem_wdata, 0);
    end
    if (sb_en && ((eg0 && !w0) || (eg1 && !w1))) begin
      e.port = eg1 ? 1 : 0;
      e.data = erd;
      e.cyc  = cyc + RD_LAT;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input logic rst_v);
    step(rst_v, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  // Response monitor: pops the scoreboard whenever a response appears and
  // tracks the value each rdata port must hold.
  initial begin
    exp_t          e;
    logic [DW-1:0] m0 = '0, m1 = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        m0 = '0;
        m1 = '0;
      end
      if (rvalid0 && rvalid1) begin
        chk("rvalid_both", {rvalid0, rvalid1}, 2'b00);
      end else if (rvalid0 || rvalid1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", {rvalid0, rvalid1}, 2'b00);
        end else begin
          e = sb.pop_front();
          chk("rvalid_port", rvalid1 ? 1 : 0, e.port);
          chk("rvalid_cycle", cyc, e.cyc);
          if (e.port == 0) m0 = e.data;
          else             m1 = e.data;
        end
      end
      chk("rdata0", rdata0, m0);
      chk("rdata1", rdata1, m1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset: nothing granted even with a request present.
    step(1, 1, 0, 0, 32'h10, '0, 0, 0, 0, '0, '0, 0, 0, '0);
    idle(1);
    chk("reset_rvalid0", rvalid0, 0);
    chk("reset_rdata0", rdata0, 0);

    // Conflict straight after reset.
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      step(0, 1, 0, 0, 32'h0, '0, 1, 0, 0, 32'h4, '0,
           (i % 2 == 0), (i % 2 == 1),
           (i % 2 == 0) ? 32'h1111_0000 : 32'h2222_0004);
`else
      step(0, 1, 0, 0, 32'h0, '0, 1, 0, 0, 32'h4, '0, 1, 0, 32'h1111_0000);
`endif
    end
    for (int i = 0; i < RD_LAT; i++) idle(0);

    // Single read.
    step(0, 1, 0, 0, 32'h10, '0, 0, 0, 0, '0, '0, 1, 0, 32'hDEAD_BEEF);
    for (int i = 0; i < RD_LAT; i++) idle(0);

    // Locked read-modify-write by port 1 while port 0 waits.
    step(0, 0, 0, 0, '0, '0, 1, 0, 1, 32'h20, '0, 0, 1, 32'h5555_0020);
    step(0, 1, 0, 0, 32'h4, '0, 1, 1, 0, 32'h20, 32'hCAFE_F00D, 0, 1, '0);
    step(0, 1, 0, 0, 32'h4, '0, 0, 0, 0, '0, '0, 1, 0, 32'h2222_0004);
    step(0, 0, 0, 0, '0, '0, 1, 0, 0, 32'h20, '0, 0, 1, 32'hCAFE_F00D);

    // Lock held back-to-back, then abandoned.
    step(0, 1, 0, 1, 32'h8, '0, 0, 0, 0, '0, '0, 1, 0, 32'h3333_0008);
    step(0, 1, 0, 1, 32'h0, '0, 1, 0, 0, 32'hC, '0, 1, 0, 32'h1111_0000);
    step(0, 0, 0, 0, '0, '0, 1, 0, 0, 32'hC, '0, 0, 0, '0);
    step(0, 0, 0, 0, '0, '0, 1, 0, 0, 32'hC, '0, 0, 1, 32'h4444_000C);

    // Lock from the losing port is ignored.
    step(0, 1, 0, 0, 32'h0, '0, 1, 0, 1, 32'h4, '0, 1, 0, 32'h1111_0000);
    step(0, 1, 0, 0, 32'h8, '0, 0, 0, 0, '0, '0, 1, 0, 32'h3333_0008);
    for (int i = 0; i < RD_LAT; i++) idle(0);

    // Pipelined reads on consecutive cycles.
    step(0, 1, 0, 0, 32'h0, '0, 0, 0, 0, '0, '0, 1, 0, 32'h1111_0000);
    step(0, 1, 0, 0, 32'h4, '0, 0, 0, 0, '0, '0, 1, 0, 32'h2222_0004);
    step(0, 1, 0, 0, 32'h8, '0, 0, 0, 0, '0, '0, 1, 0, 32'h3333_0008);
    for (int i = 0; i < RD_LAT; i++) idle(0);

    // Reset with a read in flight: its response must never appear.
    sb_en = 1'b0;
    step(0, 1, 0, 0, 32'h10, '0, 0, 0, 0, '0, '0, 1, 0, '0);
    sb_en = 1'b1;
    idle(1);
    idle(0);
    chk("post_rst_rvalid0", rvalid0, 0);
    chk("post_rst_rvalid1", rvalid1, 0);
    chk("post_rst_rdata0", rdata0, 0);
    chk("post_rst_rdata1", rdata1, 0);
    chk("post_rst_mem_en", mem_en, 0);
    for (int i = 0; i < RD_LAT; i++) idle(0);

    // After reset port 0 wins the first conflict in either configuration.
    step(0, 1, 0, 0, 32'h0, '0, 1, 0, 0, 32'h4, '0, 1, 0, 32'h1111_0000);
    for (int i = 0; i < RD_LAT + 2; i++) idle(0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the core load/store path (port 0) and the debug/program-loader path (port 1). It sits between the requesters and `Data_mem` and drives the memory's enable, read/write, address and write data. It returns read data to the requester that issued the read, with a fixed, pipelined read latency. A lock mechanism gives a requester atomic back-to-back ownership, for example for read-modify-write sequences.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `RD_LAT`, default 1: memory read latency in cycles; legal range 1..4.

- `clk` input 1: single clock; everything samples on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0`, `req1` input 1 each: request valid, port 0 / port 1.
- `we0`, `we1` input 1 each: 1 = write, 0 = read.
- `lock0`, `lock1` input 1 each: keep ownership after this access.
- `addr0`, `addr1` input AW each: byte address.
- `wdata0`, `wdata1` input DW each: write data.
- `gnt0`, `gnt1` output 1 each: request accepted this cycle (combinational).
- `rvalid0`, `rvalid1` output 1 each: read data valid for this port.
- `rdata0`, `rdata1` output DW each: read data.
- `mem_en` output 1: memory access this cycle.
- `mem_rw` output 1: 1 = write, 0 = read. Matches the `MemRW` polarity.
- `mem_addr` output AW: memory address.
- `mem_wdata` output DW: memory write data.
- `mem_rdata` input DW: memory read data, valid `RD_LAT` cycles after the read was issued.

## Operation
- Requesters hold `req`, `we`, `lock`, `addr` and `wdata` stable until they see `gnt`. At most one grant is issued per cycle.
- On grant, the arbiter passes the winner's fields to `mem_*` in the same cycle and asserts `mem_en`. When no port is granted, `mem_en` = 0 and `mem_addr`, `mem_wdata` and `mem_rw` are 0.
- A write completes at `gnt`. No response is returned for a write.
- For a read, the arbiter pushes the owner ID into a `RD_LAT`-deep valid/owner shift register. When the entry emerges, it asserts `rvalid` for that owner and captures `mem_rdata` onto that owner's `rdata`.
- `rdata` of the non-owning port holds its last value. `rvalid` is a one-cycle pulse.
- Reads are pipelined: a new grant may issue every cycle, including while earlier reads are still in flight. Responses come back in issue order.
- Ownership FSM:
  - States are `ARB` (reset), `LOCK0` and `LOCK1`.
  - `ARB`: select the winner by arbitration policy (see Configuration). If the winner's `lock` is 1 at grant, go to `LOCKn`.
  - `LOCKn`: only port n can be granted. The other port's `req` is ignored and its `gnt` = 0.
  - `LOCKn` → `ARB` happens on either of two events:
    - a granted access from port n with `lock` = 0 (that access completes normally);
    - any cycle with `req` of port n = 0 (abandoned lock).
- `lock` from a port that loses arbitration has no effect.
- Address and data pass through unmodified; alignment is the requester's responsibility.

## Timing
- Grant latency is 0: `gnt` and `mem_en` are asserted in the same cycle as `req`, when that port wins.
- Read data: `rvalid` is asserted exactly `RD_LAT` cycles after the `gnt` cycle.
- Reset values:
  - `gnt*` = 0, `rvalid*` = 0, `rdata*` = 0, `mem_en` = 0.
  - FSM = `ARB`; the round-robin pointer favours port 0 first.
  - The shift register is cleared.
- Reset asserted with reads in flight: those `rvalid` pulses are never produced.
- Outputs are 0 during the reset cycle, even when `req` is asserted.
- If both ports request every cycle in round-robin mode, grants alternate 0,1,0,1…
- A lock-held port can issue a back-to-back grant every cycle. The other port waits indefinitely; bounding that wait is the locker's responsibility.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - A one-bit pointer records the last port granted in `ARB`; on a conflict, the other port wins.
  - The pointer updates only on a grant made in `ARB`.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins a conflict in `ARB`. No pointer register is implemented.
- Lock behaviour is identical in both configurations.

## Test plan
- Single read, `RD_LAT`=1:
  - Stimulus: `req0`=1, `we0`=0, `addr0`=0x10; memory returns 0xDEADBEEF.
  - Required: `gnt0` and `mem_en` in cycle 0 with `mem_rw`=0 and `mem_addr`=0x10; cycle 1 `rvalid0`=1 with `rdata0`=0xDEADBEEF; `rvalid1` stays 0.
- Conflict with `DMEM_ARB_RR_EN` defined:
  - Stimulus: both ports read continuously for 4 cycles after reset.
  - Required: grants 0,1,0,1; `rvalid` pulses follow the same order.
  - Without the macro, the same stimulus gives port 0 four grants and `gnt1`=0 throughout.
- Lock RMW:
  - Stimulus: port 1 reads 0x20 with `lock1`=1, then writes 0x20 with `lock1`=0 while `req0` is held high.
  - Required: `gnt0`=0 through both port 1 accesses; port 0 is granted in the cycle after the unlocked write.
- Abandoned lock:
  - Stimulus: port 0 is granted with `lock0`=1, then drops `req0` for 1 cycle while port 1 requests.
  - Required: FSM returns to `ARB` and `gnt1` is asserted in the next cycle.
- Pipelined reads, `RD_LAT`=3:
  - Stimulus: port 0 issues reads to 0x0, 0x4 and 0x8 on consecutive cycles.
  - Required: `rvalid0` is asserted in cycles 3, 4 and 5 with the data in issue order.
- Reset mid-read, `RD_LAT`=2:
  - Stimulus: a read is granted in cycle 0 and `rst` is asserted in cycle 1.
  - Required: no `rvalid` in cycle 2; all outputs are 0 in cycle 2.
